// File: rtl/dram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dram_req_arbiter_if
//  Brief    : Requester-side channel of the DRAM request arbiter. A requester
//             holds valid/payload until done; the arbiter returns a one-cycle
//             done pulse with registered read data and an error flag.
//  Revision : 1.0  initial release
// ============================================================================
interface dram_req_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    // Requester (core pipeline) side
    modport master (
        output valid, rw, addr, wdata,
        input  done, rdata, err
    );

    // Arbiter side
    modport slave (
        input  valid, rw, addr, wdata,
        output done, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/dram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dram_req_arbiter
//  Brief    : Two-port arbiter in front of the single DRAM request/response
//             port. One transaction outstanding at a time, round-robin or
//             fixed-priority grant, registered request capture and a response
//             timeout that completes the requester with an error flag.
//  Revision : 1.0  initial release
// ============================================================================
module dram_req_arbiter #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    dram_req_arbiter_if.slave      m0,
    dram_req_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0]      dram_req_addr,
    output logic [DATA_W-1:0]      dram_req_data,
    output logic                   dram_req_rw,
    output logic                   dram_req_valid,
    input  wire logic [DATA_W-1:0] dram_res_data,
    input  wire logic              dram_res_ready,
    output logic                   busy
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1 (at least one bit)
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              last_grant;
    logic              grant;
    logic              arb_sel;
    logic              any_valid;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_rw;

    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;

    assign any_valid   = m0.valid | m1.valid;
    assign timeout_hit = (cnt == CNT_LAST);

    // Arbitration: a tie goes to port 0 in fixed mode, else to the port not granted last
    always_comb begin
        arb_sel = 1'b0;
        if (m0.valid && m1.valid) begin
            arb_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            arb_sel = m1.valid;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ready takes precedence over timeout in WAIT
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (any_valid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (dram_res_ready || timeout_hit) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Request latch, timeout counter and per-port result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_rw     <= 1'b0;
            cnt        <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant      <= arb_sel;
                        last_grant <= arb_sel;
                        lat_addr   <= arb_sel ? m1.addr  : m0.addr;
                        lat_data   <= arb_sel ? m1.wdata : m0.wdata;
                        lat_rw     <= arb_sel ? m1.rw    : m0.rw;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    if (dram_res_ready) begin
                        // Writes complete with zero data
                        if (grant) begin
                            rdata1 <= lat_rw ? '0 : dram_res_data;
                            err1   <= 1'b0;
                        end else begin
                            rdata0 <= lat_rw ? '0 : dram_res_data;
                            err0   <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        if (grant) begin
                            rdata1 <= '0;
                            err1   <= 1'b1;
                        end else begin
                            rdata0 <= '0;
                            err0   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dram_req_valid = (state == ST_ISSUE);
    assign dram_req_addr  = lat_addr;
    assign dram_req_data  = lat_data;
    assign dram_req_rw    = lat_rw;
    assign busy           = (state != ST_IDLE);

    assign m0.done  = (state == ST_DONE) && !grant;
    assign m1.done  = (state == ST_DONE) &&  grant;
    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;
    assign m0.err   = err0;
    assign m1.err   = err1;

endmodule
`default_nettype wire

// File: tb/tb_dram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_req_arbiter
//  Brief    : Directed self-checking bench. Two arbiters (round-robin and
//             fixed-priority, both with an 8-cycle timeout) receive identical
//             stimulus; expected values are hand-computed per scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_req_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    logic [ADDR_W-1:0] rr_req_addr, fp_req_addr;
    logic [DATA_W-1:0] rr_req_data, fp_req_data;
    logic              rr_req_rw, fp_req_rw;
    logic              rr_req_valid, fp_req_valid;
    logic              rr_busy, fp_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_req_cnt = 0;
    int c0;

    dram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0a ();
    dram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1a ();
    dram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0b ();
    dram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1b ();

    dram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk            (clk),
        .rstn           (rstn),
        .m0             (m0a),
        .m1             (m1a),
        .dram_req_addr  (rr_req_addr),
        .dram_req_data  (rr_req_data),
        .dram_req_rw    (rr_req_rw),
        .dram_req_valid (rr_req_valid),
        .dram_res_data  (res_data),
        .dram_res_ready (res_ready),
        .busy           (rr_busy)
    );

    dram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk            (clk),
        .rstn           (rstn),
        .m0             (m0b),
        .m1             (m1b),
        .dram_req_addr  (fp_req_addr),
        .dram_req_data  (fp_req_data),
        .dram_req_rw    (fp_req_rw),
        .dram_req_valid (fp_req_valid),
        .dram_res_data  (res_data),
        .dram_res_ready (res_ready),
        .busy           (fp_busy)
    );

    always #5 clk = ~clk;

    // Count request strobes of the round-robin instance
    always @(posedge clk) begin
        if (rr_req_valid) rr_req_cnt <= rr_req_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic rw,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            m0a.valid = v; m0a.rw = rw; m0a.addr = a; m0a.wdata = d;
            m0b.valid = v; m0b.rw = rw; m0b.addr = a; m0b.wdata = d;
        end else begin
            m1a.valid = v; m1a.rw = rw; m1a.addr = a; m1a.wdata = d;
            m1b.valid = v; m1b.rw = rw; m1b.addr = a; m1b.wdata = d;
        end
    endtask

    initial begin
        rstn      = 1'b0;
        res_data  = '0;
        res_ready = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        // Reset state
        check("rst_busy",      rr_busy, 0);
        check("rst_req_valid", rr_req_valid, 0);
        check("rst_req_addr",  rr_req_addr, 0);
        check("rst_m0_done",   m0a.done, 0);
        check("rst_m0_rdata",  m0a.rdata, 0);
        check("rst_m1_err",    m1a.err, 0);
        check("rst_fp_busy",   fp_busy, 0);
        rstn = 1'b1;
        tick();

        // Single read on port 0, ready on the second WAIT cycle
        c0 = rr_req_cnt;
        drive(0, 1'b1, 1'b0, 27'h0000100, 32'h0);
        tick();
        check("rd_req_valid", rr_req_valid, 1);
        check("rd_req_addr",  rr_req_addr, 27'h0000100);
        check("rd_req_rw",    rr_req_rw, 0);
        check("rd_busy",      rr_busy, 1);
        tick();
        check("rd_req_valid_wait", rr_req_valid, 0);
        tick();
        res_data  = 32'hCAFEF00D;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("rd_m0_done",  m0a.done, 1);
        check("rd_m0_rdata", m0a.rdata, 32'hCAFEF00D);
        check("rd_m0_err",   m0a.err, 0);
        check("rd_m1_done",  m1a.done, 0);
        check("rd_req_cnt",  rr_req_cnt, c0 + 1);
        drive(0, 1'b0, 1'b0, 27'h0000100, 32'h0);
        tick();
        check("rd_m0_done_low",   m0a.done, 0);
        check("rd_m0_rdata_hold", m0a.rdata, 32'hCAFEF00D);
        check("rd_busy_idle",     rr_busy, 0);

        // Write on port 1 at the top address; ready in the first WAIT cycle
        drive(1, 1'b1, 1'b1, 27'h7FFFFFF, 32'h12345678);
        tick();
        check("wr_req_valid", rr_req_valid, 1);
        check("wr_req_addr",  rr_req_addr, 27'h7FFFFFF);
        check("wr_req_data",  rr_req_data, 32'h12345678);
        check("wr_req_rw",    rr_req_rw, 1);
        tick();
        res_data  = 32'hDEADBEEF;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("wr_m1_done",  m1a.done, 1);
        check("wr_m1_rdata", m1a.rdata, 0);
        check("wr_m1_err",   m1a.err, 0);
        check("wr_m0_done",  m0a.done, 0);
        drive(1, 1'b0, 1'b1, 27'h7FFFFFF, 32'h12345678);
        tick();
        check("wr_req_addr_hold", rr_req_addr, 27'h7FFFFFF);
        check("wr_m0_rdata_hold", m0a.rdata, 32'hCAFEF00D);

        // Contention: both ports valid for four back-to-back transactions
        drive(0, 1'b1, 1'b0, 27'h0000010, 32'h0);
        drive(1, 1'b1, 1'b0, 27'h0000020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic exp_g;
            exp_g = logic'(k % 2);
            tick();
            check("ct_req_valid",  rr_req_valid, 1);
            check("ct_rr_addr",    rr_req_addr, exp_g ? 27'h20 : 27'h10);
            check("ct_fp_addr",    fp_req_addr, 27'h10);
            tick();
            check("ct_req_valid_wait", rr_req_valid, 0);
            res_data  = 32'h1000 + k;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("ct_rr_m0_done", m0a.done, !exp_g);
            check("ct_rr_m1_done", m1a.done, exp_g);
            check("ct_rr_rdata",   exp_g ? m1a.rdata : m0a.rdata, 32'h1000 + k);
            check("ct_fp_m0_done", m0b.done, 1);
            check("ct_fp_m1_done", m1b.done, 0);
            tick();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Timeout: no ready, error completion 8 cycles after entering WAIT
        drive(0, 1'b1, 1'b0, 27'h0000055, 32'h0);
        tick();
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_m0_done_early", m0a.done, 0);
        end
        tick();
        check("to_m0_done",  m0a.done, 1);
        check("to_m0_err",   m0a.err, 1);
        check("to_m0_rdata", m0a.rdata, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        res_data  = 32'h77777777;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("late_busy",    rr_busy, 0);
        check("late_m0_done", m0a.done, 0);
        check("late_req_vld", rr_req_valid, 0);
        tick();
        check("late_busy2",   rr_busy, 0);
        check("late_rdata",   m0a.rdata, 0);
        check("late_err",     m0a.err, 1);

        // Ready arrives in the very cycle the timeout fires: ready wins
        drive(1, 1'b1, 1'b0, 27'h0000066, 32'h0);
        tick();
        tick();
        for (int i = 1; i < 8; i++) tick();
        res_data  = 32'hA5A5A5A5;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("tie_m1_done",  m1a.done, 1);
        check("tie_m1_err",   m1a.err, 0);
        check("tie_m1_rdata", m1a.rdata, 32'hA5A5A5A5);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Spurious ready in IDLE changes nothing
        res_data  = 32'hFFFFFFFF;
        res_ready = 1'b1;
        tick();
        tick();
        check("sp_busy",     rr_busy, 0);
        check("sp_req_vld",  rr_req_valid, 0);
        check("sp_m1_done",  m1a.done, 0);
        check("sp_m1_rdata", m1a.rdata, 32'hA5A5A5A5);
        check("sp_m0_err",   m0a.err, 1);
        res_ready = 1'b0;

        // Reset asserted in WAIT aborts immediately
        drive(0, 1'b1, 1'b0, 27'h0000099, 32'h0);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("ar_busy",     rr_busy, 0);
        check("ar_req_addr", rr_req_addr, 0);
        check("ar_req_vld",  rr_req_valid, 0);
        check("ar_m0_rdata", m0a.rdata, 0);
        check("ar_m0_err",   m0a.err, 0);
        check("ar_m1_rdata", m1a.rdata, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        res_data  = 32'h12121212;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ar_busy_after", rr_busy, 0);
        check("ar_m0_done",    m0a.done, 0);
        check("ar_m1_done",    m1a.done, 0);
        check("ar_m0_rdata2",  m0a.rdata, 0);
        tick();
        check("ar_busy_final", rr_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares the single DRAM request/response port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Sits between the core pipeline and the DRAM controller top, in the core's clock domain.
- Serialises transactions: exactly one is outstanding at a time.
- Provides round-robin or fixed-priority arbitration, registered request capture, and a response timeout that completes the requester with an error flag.

Parameters:
ADDR_W, 27, DRAM word-address width
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties
TIMEOUT_CYCLES, 1023, WAIT-state cycles before forced error completion (must be >= 1)

Ports:
clk  in  1  core clock; all logic on rising edge
rstn  in  1  asynchronous active-low reset
m0_valid  in  1  port 0 request; held high until m0_done
m0_rw  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  request address
m0_wdata  in  DATA_W  write data
m0_done  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data; valid while m0_done = 1
m0_err  out  1  timeout flag; valid while m0_done = 1
m1_valid, m1_rw, m1_addr, m1_wdata, m1_done, m1_rdata, m1_err  same as port 0
dram_req_addr  out  ADDR_W  to DRAM controller
dram_req_data  out  DATA_W  write data to DRAM
dram_req_rw  out  1  1 = write
dram_req_valid  out  1  one-cycle request strobe
dram_res_data  in  DATA_W  response data
dram_res_ready  in  1  one-cycle response strobe (read data valid / write accepted)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn low, asynchronous): state = IDLE; all outputs 0; latched request 0; timeout counter 0; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that port.
  - If both are high, FIXED_PRIO=1 grants port 0; otherwise grant the port != last_grant.
  - On a grant, latch addr/wdata/rw and the grant index, update last_grant, then go to ISSUE.
- ISSUE: dram_req_valid = 1 for exactly this one cycle; addr/data/rw are driven from the latch. Clear the counter and go to WAIT.
- dram_req_addr/data/rw hold their latched values from ISSUE until the next grant. They are never driven from the live requester inputs.
- WAIT:
  - On dram_res_ready = 1, capture the result and go to DONE. The result is dram_res_data for a read and 0 for a write; err = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ready, capture result 0 with err = 1 and go to DONE.
  - If ready and timeout occur in the same cycle, ready wins (err = 0).
- DONE:
  - Only the granted port sees done = 1 for this single cycle, with rdata/err registered. The other port's done stays 0.
  - Always go to IDLE next.
  - rdata/err hold their values after done until that port's next completion.
- Latency: from the IDLE sample of valid to dram_req_valid is 1 cycle. From dram_res_ready to mN_done is 1 cycle. Minimum occupancy is 4 cycles per transaction (IDLE→ISSUE→WAIT→DONE) when ready arrives in the first WAIT cycle.
- Requester rule: valid and payload stay stable until done. valid drops on the edge after done unless a new request follows; a valid still high in IDLE counts as a new request.
- A valid dropped before done is a protocol violation. The transaction still completes from the latch.
- dram_res_ready outside WAIT (including a late response after timeout) is ignored. No state or output changes.
- Reset asserted mid-transaction aborts immediately. No done is issued, and an in-flight DRAM response after reset release is ignored per the previous rule.
- Round-robin guarantees each port at most one transaction of wait while the other is serviced.

Test Plan:
- Single read port 0: addr=0x0000100; dram_res_ready with data 0xCAFEF00D on the 2nd WAIT cycle → dram_req_valid pulses once with addr 0x0000100, rw=0; m0_done pulses one cycle later with m0_rdata=0xCAFEF00D, m0_err=0; m1_done stays 0.
- Write port 1: addr=0x7FFFFFF, wdata=0x12345678, rw=1 → dram_req_data=0x12345678, dram_req_rw=1; on ready, m1_done=1 with m1_rdata=0.
- Contention, FIXED_PRIO=0, both valid continuously for 4 transactions, ready immediate → grant order 0,1,0,1 and dram_req_valid every 4 cycles. With FIXED_PRIO=1 → order 0,0,0,0.
- Timeout with TIMEOUT_CYCLES=8 and ready never asserted → m0_done with m0_err=1 and m0_rdata=0 exactly 8 cycles after entering WAIT; a late ready 3 cycles later produces no done and busy stays 0.
- Ready and timeout in the same cycle → err=0 with data captured. Spurious ready in IDLE → no outputs change.
- rstn pulled low in WAIT → all outputs 0 asynchronously; after release, with no valid, busy stays 0 and the pending DRAM ready is ignored.
